// File: rtl/rv32i_regfile_wrarb_pkg.sv
// Shared rv32i register-file constants and FSM encodings for the write-port arbiter.
// The CLEAR state is only referenced when RV32I_RF_CLEAR_EN is defined.
package rv32i_regfile_wrarb_pkg;

    localparam int REG_COUNT  = 32;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    localparam logic [REG_ADDR_W-1:0] X0_ADDR        = '0;
    localparam logic [REG_ADDR_W-1:0] FIRST_CLR_ADDR = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] LAST_REG_ADDR  = REG_ADDR_W'(REG_COUNT - 1);

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // x0 is hardwired to zero, so a write aimed at it must never reach the array
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr != X0_ADDR;
    endfunction

endpackage

// File: rtl/rv32i_regfile_wrarb.sv
// Single write-port arbiter for the rv32i register file: writeback has priority, debug
// is forced through after STARVE_LIMIT denied cycles. RV32I_RF_CLEAR_EN adds a zeroing pass after reset.
module rv32i_regfile_wrarb
    import rv32i_regfile_wrarb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_wr,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_wb_stall,
    input  logic                  i_dbg_valid,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    input  logic [XLEN-1:0]       i_dbg_data,
    output logic                  o_dbg_ready,
    output logic                  o_rf_wr,
    output logic [REG_ADDR_W-1:0] o_rf_addr,
    output logic [XLEN-1:0]       o_rf_data,
    output logic                  o_busy
);

    localparam int              WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  rf_wr_q, rf_wr_d;
    logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;

    logic run;
    logic starve;
    logic dbg_grant;
    logic wb_grant;

`ifdef RV32I_RF_CLEAR_EN
    rf_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] clr_addr_q, clr_addr_d;

    assign run    = (state_q == RF_RUN);
    assign o_busy = ~run;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (!run) begin
            if (clr_addr_q == LAST_REG_ADDR) begin
                state_d = RF_RUN;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end
`else
    assign run    = 1'b1;
    assign o_busy = 1'b0;
`endif

    // Starvation overrides writeback for exactly one cycle, then the counter restarts
    assign starve      = run && i_dbg_valid && (wait_q == WAIT_MAX);
    assign dbg_grant   = !i_rst && run && i_dbg_valid && (!i_wb_wr || starve);
    assign wb_grant    = run && i_wb_wr && !starve;
    assign o_dbg_ready = dbg_grant;
    assign o_wb_stall  = !run || starve;

    always_comb begin
        wait_d = '0;
        if (run && i_dbg_valid && !dbg_grant) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end
    end

    always_comb begin
        rf_wr_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (dbg_grant) begin
            rf_wr_d   = writes_reg(i_dbg_addr);
            rf_addr_d = i_dbg_addr;
            rf_data_d = i_dbg_data;
        end else if (wb_grant) begin
            rf_wr_d   = writes_reg(i_wb_addr);
            rf_addr_d = i_wb_addr;
            rf_data_d = i_wb_data;
        end
`ifdef RV32I_RF_CLEAR_EN
        if (!run) begin
            rf_wr_d   = 1'b1;
            rf_addr_d = clr_addr_q;
            rf_data_d = '0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_q     <= '0;
            rf_wr_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
`ifdef RV32I_RF_CLEAR_EN
            state_q    <= RF_CLEAR;
            clr_addr_q <= FIRST_CLR_ADDR;
`endif
        end else begin
            wait_q     <= wait_d;
            rf_wr_q    <= rf_wr_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
`ifdef RV32I_RF_CLEAR_EN
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    assign o_rf_wr   = rf_wr_q;
    assign o_rf_addr = rf_addr_q;
    assign o_rf_data = rf_data_q;

endmodule

// File: tb/tb_rv32i_regfile_wrarb.sv
// Scoreboard bench for rv32i_regfile_wrarb: the driver queues expected register-file
// writes and a negedge monitor retires them; also exercises the RV32I_RF_CLEAR_EN build.
module tb_rv32i_regfile_wrarb;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

`ifdef RV32I_RF_CLEAR_EN
    localparam logic CLR_BUILD = 1'b1;
`else
    localparam logic CLR_BUILD = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wb_wr = 1'b0;
    logic [4:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        i_dbg_valid = 1'b0;
    logic [4:0]  i_dbg_addr = '0;
    logic [31:0] i_dbg_data = '0;
    logic        o_wb_stall;
    logic        o_dbg_ready;
    logic        o_rf_wr;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic        o_busy;

    wr_t  exp_q[$];
    wr_t  mon_w;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic prev_wr_exp  = 1'b0;

    rv32i_regfile_wrarb #(.STARVE_LIMIT(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb_wr     (i_wb_wr),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_wb_stall  (o_wb_stall),
        .i_dbg_valid (i_dbg_valid),
        .i_dbg_addr  (i_dbg_addr),
        .i_dbg_data  (i_dbg_data),
        .o_dbg_ready (o_dbg_ready),
        .o_rf_wr     (o_rf_wr),
        .o_rf_addr   (o_rf_addr),
        .o_rf_data   (o_rf_data),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock of stimulus: handshakes are checked combinationally, the resulting write is queued
    task automatic apply_stimulus(
        input string       name,
        input logic        rst,
        input logic        wb_wr,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data,
        input logic        dbg_valid,
        input logic [4:0]  dbg_addr,
        input logic [31:0] dbg_data,
        input logic        exp_stall,
        input logic        exp_ready,
        input logic        exp_busy,
        input logic [4:0]  clr_addr
    );
        wr_t  w;
        logic wr_now;
        @(posedge i_clk);
        #1;
        i_rst       = rst;
        i_wb_wr     = wb_wr;
        i_wb_addr   = wb_addr;
        i_wb_data   = wb_data;
        i_dbg_valid = dbg_valid;
        i_dbg_addr  = dbg_addr;
        i_dbg_data  = dbg_data;
        @(negedge i_clk);
        check_output({name, " wb_stall"}, {31'd0, o_wb_stall}, {31'd0, exp_stall});
        check_output({name, " dbg_ready"}, {31'd0, o_dbg_ready}, {31'd0, exp_ready});
        check_output({name, " busy"}, {31'd0, o_busy}, {31'd0, exp_busy});
        check_output({name, " rf_wr"}, {31'd0, o_rf_wr}, {31'd0, prev_wr_exp});
        wr_now = 1'b0;
        w      = '0;
        if (!rst) begin
            if (exp_busy) begin
                w      = '{addr: clr_addr, data: 32'd0};
                wr_now = 1'b1;
            end else if (exp_ready) begin
                w      = '{addr: dbg_addr, data: dbg_data};
                wr_now = (dbg_addr != 5'd0);
            end else if (wb_wr && !exp_stall) begin
                w      = '{addr: wb_addr, data: wb_data};
                wr_now = (wb_addr != 5'd0);
            end
        end
        if (wr_now) exp_q.push_back(w);
        prev_wr_exp = wr_now;
    endtask

    always @(negedge i_clk) begin
        if (o_rf_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", o_rf_addr, o_rf_data);
            end else begin
                mon_w = exp_q.pop_front();
                check_output("rf_addr", {27'd0, o_rf_addr}, {27'd0, mon_w.addr});
                check_output("rf_data", o_rf_data, mon_w.data);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_output("reset rf_wr", {31'd0, o_rf_wr}, 32'd0);
        check_output("reset rf_addr", {27'd0, o_rf_addr}, 32'd0);
        check_output("reset rf_data", o_rf_data, 32'd0);

        // Requests held during reset must not be acknowledged or written
        apply_stimulus("rst0", 1, 1, 5'd4, 32'h4444_4444, 1, 5'd6, 32'h6666_6666, CLR_BUILD, 0, CLR_BUILD, 5'd0);
        apply_stimulus("rst1", 1, 1, 5'd4, 32'h4444_4444, 1, 5'd6, 32'h6666_6666, CLR_BUILD, 0, CLR_BUILD, 5'd0);

`ifdef RV32I_RF_CLEAR_EN
        for (int a = 1; a <= 10; a++)
            apply_stimulus("clear_a", 0, 1, 5'd2, 32'h1111, 1, 5'd3, 32'h2222, 1, 0, 1, 5'(a));
        apply_stimulus("clear_rst", 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0, 1, 5'd0);
        for (int a = 1; a <= 31; a++)
            apply_stimulus("clear_b", 0, 1, 5'd2, 32'h1111, 1, 5'd3, 32'h2222, 1, 0, 1, 5'(a));
`endif

        apply_stimulus("wb_write", 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        apply_stimulus("dbg_write", 0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234_5678, 0, 1, 0, 5'd0);
        apply_stimulus("wb_x0", 0, 1, 5'd0, 32'hAAAA_AAAA, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        apply_stimulus("idle0", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        apply_stimulus("dbg_x0", 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h5555_5555, 0, 1, 0, 5'd0);
        apply_stimulus("idle1", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);

        // Eight denied cycles, then debug forced through on the ninth
        for (int i = 0; i < 8; i++)
            apply_stimulus("starve_wait", 0, 1, 5'd9, 32'hCAFE_F00D, 1, 5'd3, 32'h0BAD_C0DE, 0, 0, 0, 5'd0);
        apply_stimulus("starve_force", 0, 1, 5'd9, 32'hCAFE_F00D, 1, 5'd3, 32'h0BAD_C0DE, 1, 1, 0, 5'd0);
        apply_stimulus("wb_resume", 0, 1, 5'd9, 32'hCAFE_F00D, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);

        // Dropping debug valid mid-wait restarts the count from zero
        for (int i = 0; i < 5; i++)
            apply_stimulus("partial_wait", 0, 1, 5'd10, 32'h0000_00A0 + 32'(i), 1, 5'd11, 32'hB0B0_B0B0, 0, 0, 0, 5'd0);
        apply_stimulus("dbg_drop", 0, 1, 5'd12, 32'h0000_0C0C, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 8; i++)
            apply_stimulus("restart_wait", 0, 1, 5'd13, 32'h0000_1300 + 32'(i), 1, 5'd14, 32'hE0E0_E0E0, 0, 0, 0, 5'd0);
        apply_stimulus("restart_force", 0, 1, 5'd13, 32'h0000_13FF, 1, 5'd14, 32'hE0E0_E0E0, 1, 1, 0, 5'd0);

        apply_stimulus("drain0", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        apply_stimulus("drain1", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_wrarb.md
RV32I_REGFILE_WRARB -- requirements
Module: rv32i_regfile_wrarb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: the number of consecutive denied cycles before the debug requester is forced through.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_wb_wr, input, 1 bit: writeback write request from pipeline stage 5.
REQ-005 SHALL have ports i_wb_addr, input, 5 bits, and i_wb_data, input, 32 bits: the writeback destination register and its data.
REQ-006 SHALL have port o_wb_stall, output, 1 bit: the writeback request is not accepted this cycle, so upstream holds it.
REQ-007 SHALL have port i_dbg_valid, input, 1 bit: debug/external write request.
REQ-008 SHALL have ports i_dbg_addr, input, 5 bits, and i_dbg_data, input, 32 bits: the debug write target and its data.
REQ-009 SHALL have port o_dbg_ready, output, 1 bit: the debug write is accepted this cycle.
REQ-010 SHALL have ports o_rf_wr, output, 1 bit; o_rf_addr, output, 5 bits; o_rf_data, output, 32 bits: the single write port driving the base register file.
REQ-011 SHALL have port o_busy, output, 1 bit: the clear sequence is in progress and the pipeline must stall.

Function
REQ-012 SHALL implement a 2-state FSM: CLEAR and RUN.
REQ-013 In CLEAR, SHALL issue one write per cycle: o_rf_wr=1, o_rf_data=0, o_rf_addr counting 1..31, for 31 cycles.
REQ-014 After address 31 is issued, SHALL move to RUN on the next edge.
REQ-015 In CLEAR, SHALL hold o_busy=1, o_dbg_ready=0 and o_wb_stall=1, and SHALL ignore i_wb_wr and i_dbg_valid.
REQ-016 In RUN, SHALL hold o_busy=0 and SHALL give writeback priority: if i_wb_wr=1 and the starvation trigger is 0, writeback is granted, o_wb_stall=0 and o_dbg_ready=0.
REQ-017 In RUN, if i_wb_wr=0 and i_dbg_valid=1, SHALL set o_dbg_ready=1 in the same cycle; o_dbg_ready is combinational.
REQ-018 SHALL keep a wait counter that increments each cycle i_dbg_valid=1 and o_dbg_ready=0, and clears on a debug grant or when i_dbg_valid=0.
REQ-019 When the wait counter equals STARVE_LIMIT, SHALL force the starvation trigger: o_dbg_ready=1 and o_wb_stall=1 for that cycle, even if i_wb_wr=1.
REQ-020 o_wb_stall SHALL be 0 in RUN except under REQ-019.
REQ-021 The granted request SHALL appear on o_rf_wr/o_rf_addr/o_rf_data exactly 1 cycle later; these outputs are registered.
REQ-022 A granted write to address 0 SHALL complete its handshake but produce o_rf_wr=0.
REQ-023 A cycle with no grant SHALL produce o_rf_wr=0 on the next cycle; o_rf_addr and o_rf_data are don't-care when o_rf_wr=0.
REQ-024 The wait counter width SHALL be $clog2(STARVE_LIMIT+1) and SHALL saturate, never wrapping.

Reset
REQ-025 On i_rst=1 at a clock edge, SHALL clear o_rf_wr and the wait counter to 0, and o_rf_addr and o_rf_data to 0.
REQ-026 On reset, SHALL enter CLEAR with the address counter at 1 when the macro is defined, else RUN.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sequence from address 1; a write pending in the output register is discarded.
REQ-028 While i_rst=1, o_dbg_ready SHALL be 0.

Configuration
REQ-029 Macro RV32I_RF_CLEAR_EN: when defined, SHALL include the CLEAR state and address counter.
REQ-030 When RV32I_RF_CLEAR_EN is undefined, SHALL contain no CLEAR logic: the FSM is RUN only, o_busy is tied to 0, and reset goes straight to RUN.

Structure
REQ-031 FSM state encodings, REG_COUNT=32 and the x0 address constant SHALL live in the shared rv32i header package.
REQ-032 SHALL be a single module; no sub-module is needed.

Verification
REQ-033 Macro defined, reset then release -> o_busy=1 for 31 cycles, o_rf_wr=1 with addr 1..31 and data 0, then o_busy=0.
REQ-034 RUN, i_wb_wr=1, addr 5, data 0xDEADBEEF -> o_wb_stall=0; next cycle o_rf_wr=1, o_rf_addr=5, o_rf_data=0xDEADBEEF.
REQ-035 RUN, i_wb_wr=0, i_dbg_valid=1, addr 7, data 0x12345678 -> o_dbg_ready=1 same cycle; next cycle o_rf_addr=7, o_rf_data=0x12345678.
REQ-036 STARVE_LIMIT=8, i_wb_wr and i_dbg_valid held at 1 -> o_dbg_ready=0 for 8 cycles, then 1 with o_wb_stall=1 on cycle 9, then writeback resumes with its data unchanged.
REQ-037 i_wb_wr=1, addr 0 -> o_wb_stall=0, next-cycle o_rf_wr=0.
REQ-038 Reset at CLEAR cycle 10 -> sequence restarts at address 1 and takes 31 further cycles.
